// File: rtl/priority_scan_iterator.sv
// Sequential priority scanner: loads a request vector, then emits the index
// of each set bit one beat at a time, highest-first or lowest-first.
module priority_scan_iterator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned NONE_CODE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
);

  generate
    if (WIDTH < 2 || NONE_CODE < WIDTH ||
        (longint'(1) << IDX_W) <= longint'(WIDTH - 1) ||
        (longint'(1) << IDX_W) <= longint'(NONE_CODE)) begin : g_bad_params
      $error("priority_scan_iterator: illegal WIDTH/IDX_W/NONE_CODE combination");
    end
  endgenerate

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic             mode;
  logic [WIDTH-1:0] sel;
  logic [IDX_W-1:0] pick;
  logic             scanning;
  logic             empty;

  // Ascending walk: MSB-first keeps overwriting so the highest hit wins,
  // LSB-first locks onto the first hit.
  always_comb begin
    sel  = '0;
    pick = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (shadow[i] && (!mode || sel == '0)) begin
        sel    = '0;
        sel[i] = 1'b1;
        pick   = IDX_W'(i);
      end
    end
  end

  assign scanning  = (state == SCAN);
  assign empty     = (shadow == '0);
  assign in_ready  = (state == IDLE);
  assign out_valid = scanning;
  assign out_none  = scanning && empty;
  assign out_last  = scanning && ((shadow & (shadow - WIDTH'(1))) == '0);
  assign out_idx   = !scanning ? '0 : (empty ? IDX_W'(NONE_CODE) : pick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      mode   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shadow <= in_vec;
            mode   <= lsb_first;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            shadow <= shadow & ~sel;
            if (out_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_scan_iterator.sv
// Bench for priority_scan_iterator: directed cases plus random vectors,
// checked against an index list built straight from the vector bits.
module tb_priority_scan_iterator;

  localparam int NONE = 8'hF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        lsb_first;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        out_none;

  int n_checks = 0;
  int n_fail   = 0;

  priority_scan_iterator #(.WIDTH(16), .IDX_W(8), .NONE_CODE(8'hF0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .lsb_first(lsb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_none(out_none)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idx(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk_bit({tag, "_valid"}, out_valid, 1'b0);
    chk_idx({tag, "_idx"},   out_idx,   8'd0);
    chk_bit({tag, "_last"},  out_last,  1'b0);
    chk_bit({tag, "_none"},  out_none,  1'b0);
  endtask

  // Expected beat sequence: set-bit indices in scan order, or one sentinel.
  function automatic void model(input logic [15:0] v, input logic m, output int q[$]);
    q = {};
    if (v == 16'h0) q.push_back(NONE);
    else
      for (int i = 0; i < 16; i++) begin
        int b;
        b = m ? i : 15 - i;
        if (v[b]) q.push_back(b);
      end
  endfunction

  task automatic run_vec(input logic [15:0] v, input logic m, input int stall_at, input int stall_n);
    int exp_q[$];
    int n;
    model(v, m, exp_q);
    n = exp_q.size();
    @(negedge clk);
    chk_bit("idle_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_vec = v; lsb_first = m; out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          in_valid = 1'b1; in_vec = 16'($urandom); lsb_first = 1'($urandom);
          chk_bit("stall_valid", out_valid, 1'b1);
          chk_idx("stall_idx", out_idx, 8'(exp_q[k]));
          chk_bit("stall_last", out_last, k == n - 1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk_bit("beat_valid", out_valid, 1'b1);
      chk_bit("beat_ready", in_ready, 1'b0);
      chk_idx("beat_idx", out_idx, 8'(exp_q[k]));
      chk_bit("beat_last", out_last, k == n - 1);
      chk_bit("beat_none", out_none, v == 16'h0);
      in_vec = 16'($urandom); lsb_first = 1'($urandom);
      in_valid = (k == n - 1) ? 1'b0 : 1'($urandom);
      @(negedge clk);
    end
    chk_bit("done_valid", out_valid, 1'b0);
    chk_bit("done_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; lsb_first = 1'b0; out_ready = 1'b0;
    #3;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("reset_ready", in_ready, 1'b1);

    run_vec(16'h8001, 1'b0, -1, 0);
    run_vec(16'h0013, 1'b1, -1, 0);
    run_vec(16'h0000, 1'b0, -1, 0);
    run_vec(16'h0000, 1'b1, 0, 2);
    run_vec(16'h00A0, 1'b0, 0, 3);
    run_vec(16'hFFFF, 1'b0, -1, 0);
    run_vec(16'hFFFF, 1'b1, 15, 1);

    // Full vector interrupted by reset after 12 accepted beats.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 16'hFFFF; lsb_first = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk_idx("pre_rst_idx", out_idx, 8'(15 - k));
      @(negedge clk);
    end
    chk_idx("pre_rst_idx", out_idx, 8'd3);
    #2 rst = 1'b1;
    #1;
    chk_quiet("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("mid_rst_ready", in_ready, 1'b1);
    run_vec(16'h0004, 1'b0, -1, 0);

    for (int r = 0; r < 25; r++) begin
      logic [15:0] v;
      v = (r % 5 == 0) ? 16'h0 : 16'($urandom);
      run_vec(v, 1'($urandom), int'($urandom_range(0, 16)), int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
